// File: rtl/ld_st_queue.sv
`default_nettype none
// ============================================================================
// Module      : ld_st_queue
// Description : In-order load/store queue between a core and a tagged,
//               out-of-order memory. Requests are issued to memory in the
//               cycle they are accepted, tagged with their queue slot.
//               Load responses may come back in any order and are returned
//               to the core strictly in acceptance order.
//
// Ports       : clk, reset                  - clock, sync active-high reset
//               core_valid_in/rw/addr/data  - core request (rw: 1=store)
//               core_stall_out              - request not accepted this cycle
//               core_valid_out/data_out     - in-order load data to the core
//               mem_valid_out/rw/addr/data  - request issued to memory
//               mem_id_out                  - tag (queue slot) of issued request
//               mem_stall_in                - memory refuses new requests
//               mem_ready_in/id_in/data_in  - tagged load response
//               err_out                     - sticky: response hit a non-pending slot
//               perf_stall_cycles           - (LD_ST_QUEUE_PERF_EN) saturating
//               perf_loads_done             - (LD_ST_QUEUE_PERF_EN) wrapping
//
// Options     : define LD_ST_QUEUE_PERF_EN to add the two performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module ld_st_queue #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_BITS    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  core_valid_in,
    input  logic                  core_rw_in,
    input  logic [ADDR_WIDTH-1:0] core_addr_in,
    input  logic [DATA_WIDTH-1:0] core_data_in,
    output logic                  core_stall_out,
    output logic                  core_valid_out,
    output logic [DATA_WIDTH-1:0] core_data_out,
    output logic                  mem_valid_out,
    output logic                  mem_rw_out,
    output logic [ADDR_WIDTH-1:0] mem_addr_out,
    output logic [DATA_WIDTH-1:0] mem_data_out,
    output logic [ID_BITS-1:0]    mem_id_out,
    input  logic                  mem_stall_in,
    input  logic                  mem_ready_in,
    input  logic [ID_BITS-1:0]    mem_id_in,
    input  logic [DATA_WIDTH-1:0] mem_data_in,
`ifdef LD_ST_QUEUE_PERF_EN
    output logic [31:0]           perf_stall_cycles,
    output logic [31:0]           perf_loads_done,
`endif
    output logic                  err_out
);

    localparam int                c_depth      = 2 ** ID_BITS;
    localparam logic [ID_BITS:0]  c_full       = (ID_BITS + 1)'(c_depth);

    localparam logic [1:0]        c_st_free    = 2'd0;
    localparam logic [1:0]        c_st_pending = 2'd1;
    localparam logic [1:0]        c_st_done    = 2'd2;

    logic [ID_BITS-1:0]    r_head;
    logic [ID_BITS-1:0]    r_tail;
    logic [ID_BITS:0]      r_count;
    logic [1:0]            r_state      [c_depth];
    logic                  r_rw         [c_depth];
    logic [DATA_WIDTH-1:0] r_entry_data [c_depth];
    logic                  r_core_valid;
    logic [DATA_WIDTH-1:0] r_core_data;
    logic                  r_err;

    logic                  w_accept;
    logic                  w_resp_hit;
    logic                  w_retire;
    logic                  w_retire_load;

    // Stall looks only at the registered count: a slot freed by a retirement
    // on the coming edge cannot be reused in the same cycle.
    assign core_stall_out = (r_count == c_full) | mem_stall_in;
    assign w_accept       = core_valid_in & ~core_stall_out;

    assign mem_valid_out  = w_accept;
    assign mem_rw_out     = core_rw_in;
    assign mem_addr_out   = core_addr_in;
    assign mem_data_out   = core_data_in;
    assign mem_id_out     = r_tail;

    assign w_resp_hit     = mem_ready_in & (r_state[mem_id_in] == c_st_pending);
    assign w_retire       = (r_state[r_head] == c_st_done);
    assign w_retire_load  = w_retire & ~r_rw[r_head];

    assign core_valid_out = r_core_valid;
    assign core_data_out  = r_core_data;
    assign err_out        = r_err;

    // Control state. The accept slot (tail, FREE), the response slot
    // (PENDING) and the retire slot (head, DONE) are always distinct, so
    // the three updates below never collide on the same entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_core_valid <= 1'b0;
            r_core_data  <= '0;
            r_err        <= 1'b0;
            for (int i = 0; i < c_depth; i++) begin
                r_state[i] <= c_st_free;
            end
        end else begin
            if (w_accept) begin
                // Stores need no response, so they are complete on entry.
                r_state[r_tail] <= core_rw_in ? c_st_done : c_st_pending;
                r_tail          <= r_tail + 1'b1;
            end

            if (w_resp_hit) begin
                r_state[mem_id_in] <= c_st_done;
            end else if (mem_ready_in) begin
                r_err <= 1'b1;
            end

            if (w_retire) begin
                r_state[r_head] <= c_st_free;
                r_head          <= r_head + 1'b1;
            end
            r_core_valid <= w_retire_load;
            if (w_retire_load) begin
                r_core_data <= r_entry_data[r_head];
            end

            case ({w_accept, w_retire})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage carries no reset; it is only read after being written.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_rw[r_tail]         <= core_rw_in;
            r_entry_data[r_tail] <= core_data_in;
        end
        if (w_resp_hit) begin
            r_entry_data[mem_id_in] <= mem_data_in;
        end
    end

`ifdef LD_ST_QUEUE_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_loads;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_stall <= '0;
            r_perf_loads <= '0;
        end else begin
            if (core_valid_in & core_stall_out & (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 1'b1;
            end
            if (w_retire_load) begin
                r_perf_loads <= r_perf_loads + 1'b1;
            end
        end
    end

    assign perf_stall_cycles = r_perf_stall;
    assign perf_loads_done   = r_perf_loads;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ld_st_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_ld_st_queue
// Description : Directed self-checking bench for ld_st_queue (default params).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ld_st_queue;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int ID_BITS    = 4;

    logic                  clk;
    logic                  reset;
    logic                  core_valid_in;
    logic                  core_rw_in;
    logic [ADDR_WIDTH-1:0] core_addr_in;
    logic [DATA_WIDTH-1:0] core_data_in;
    logic                  core_stall_out;
    logic                  core_valid_out;
    logic [DATA_WIDTH-1:0] core_data_out;
    logic                  mem_valid_out;
    logic                  mem_rw_out;
    logic [ADDR_WIDTH-1:0] mem_addr_out;
    logic [DATA_WIDTH-1:0] mem_data_out;
    logic [ID_BITS-1:0]    mem_id_out;
    logic                  mem_stall_in;
    logic                  mem_ready_in;
    logic [ID_BITS-1:0]    mem_id_in;
    logic [DATA_WIDTH-1:0] mem_data_in;
`ifdef LD_ST_QUEUE_PERF_EN
    logic [31:0]           perf_stall_cycles;
    logic [31:0]           perf_loads_done;
`endif
    logic                  err_out;

    int n_pass;
    int n_total;

    ld_st_queue #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .ID_BITS   (ID_BITS)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .core_valid_in    (core_valid_in),
        .core_rw_in       (core_rw_in),
        .core_addr_in     (core_addr_in),
        .core_data_in     (core_data_in),
        .core_stall_out   (core_stall_out),
        .core_valid_out   (core_valid_out),
        .core_data_out    (core_data_out),
        .mem_valid_out    (mem_valid_out),
        .mem_rw_out       (mem_rw_out),
        .mem_addr_out     (mem_addr_out),
        .mem_data_out     (mem_data_out),
        .mem_id_out       (mem_id_out),
        .mem_stall_in     (mem_stall_in),
        .mem_ready_in     (mem_ready_in),
        .mem_id_in        (mem_id_in),
        .mem_data_in      (mem_data_in),
`ifdef LD_ST_QUEUE_PERF_EN
        .perf_stall_cycles(perf_stall_cycles),
        .perf_loads_done  (perf_loads_done),
`endif
        .err_out          (err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge, then settle at the falling edge where outputs are sampled
    // and inputs are changed.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        core_valid_in = 1'b0;
        core_rw_in    = 1'b0;
        core_addr_in  = '0;
        core_data_in  = '0;
        mem_stall_in  = 1'b0;
        mem_ready_in  = 1'b0;
        mem_id_in     = '0;
        mem_data_in   = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // Present one load and take the accept edge.
    task automatic issue_load(input logic [ADDR_WIDTH-1:0] addr);
        core_valid_in = 1'b1;
        core_rw_in    = 1'b0;
        core_addr_in  = addr;
        step();
        core_valid_in = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        step();
        step();
        reset = 1'b0;
        #1;
        n_total++; if (core_valid_out !== 1'b0) $display("FAIL reset_core_valid: got %b want 0", core_valid_out); else n_pass++;
        n_total++; if (core_data_out !== 32'h0) $display("FAIL reset_core_data: got %h want 0", core_data_out); else n_pass++;
        n_total++; if (err_out !== 1'b0) $display("FAIL reset_err: got %b want 0", err_out); else n_pass++;
        n_total++; if (core_stall_out !== 1'b0) $display("FAIL reset_stall: got %b want 0", core_stall_out); else n_pass++;
        n_total++; if (mem_valid_out !== 1'b0) $display("FAIL reset_mem_valid: got %b want 0", mem_valid_out); else n_pass++;
    endtask

    task automatic test_single_load();
        do_reset();
        core_valid_in = 1'b1;
        core_rw_in    = 1'b0;
        core_addr_in  = 32'h40;
        #1;
        n_total++; if (mem_valid_out !== 1'b1) $display("FAIL load_mem_valid: got %b want 1", mem_valid_out); else n_pass++;
        n_total++; if (mem_addr_out !== 32'h40) $display("FAIL load_mem_addr: got %h want 00000040", mem_addr_out); else n_pass++;
        n_total++; if (mem_id_out !== 4'd0) $display("FAIL load_mem_id: got %0d want 0", mem_id_out); else n_pass++;
        n_total++; if (mem_rw_out !== 1'b0) $display("FAIL load_mem_rw: got %b want 0", mem_rw_out); else n_pass++;
        step();
        core_valid_in = 1'b0;
        mem_ready_in  = 1'b1;
        mem_id_in     = 4'd0;
        mem_data_in   = 32'hDEADBEEF;
        step();                                   // edge N
        mem_ready_in  = 1'b0;
        n_total++; if (core_valid_out !== 1'b0) $display("FAIL load_early_valid: got %b want 0", core_valid_out); else n_pass++;
        step();                                   // edge N+1
        n_total++; if (core_valid_out !== 1'b1) $display("FAIL load_valid: got %b want 1", core_valid_out); else n_pass++;
        n_total++; if (core_data_out !== 32'hDEADBEEF) $display("FAIL load_data: got %h want deadbeef", core_data_out); else n_pass++;
        step();
        n_total++; if (core_valid_out !== 1'b0) $display("FAIL load_valid_pulse: got %b want 0", core_valid_out); else n_pass++;
        n_total++; if (err_out !== 1'b0) $display("FAIL load_err: got %b want 0", err_out); else n_pass++;
    endtask

    task automatic test_reorder();
        logic [DATA_WIDTH-1:0] want [3];
        logic [DATA_WIDTH-1:0] got  [3];
        logic [ID_BITS-1:0]    order [3];
        int                    n_got;
        want[0] = 32'h0000A0A0; want[1] = 32'h1111B1B1; want[2] = 32'h2222C2C2;
        order[0] = 4'd2; order[1] = 4'd0; order[2] = 4'd1;
        n_got = 0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            core_valid_in = 1'b1;
            core_addr_in  = 32'h100 + 32'(4 * i);
            #1;
            n_total++; if (mem_id_out !== 4'(i)) $display("FAIL reorder_tag%0d: got %0d want %0d", i, mem_id_out, i); else n_pass++;
            step();
        end
        core_valid_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < 3) begin
                mem_ready_in = 1'b1;
                mem_id_in    = order[i];
                mem_data_in  = want[order[i]];
            end else begin
                mem_ready_in = 1'b0;
            end
            step();
            if (core_valid_out === 1'b1 && n_got < 3) begin
                got[n_got] = core_data_out;
                n_got++;
            end
        end
        n_total++; if (n_got !== 3) $display("FAIL reorder_count: got %0d returns want 3", n_got); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            if (i < n_got) begin
                n_total++; if (got[i] !== want[i]) $display("FAIL reorder_data%0d: got %h want %h", i, got[i], want[i]); else n_pass++;
            end
        end
    endtask

    task automatic test_full();
        do_reset();
        core_valid_in = 1'b1;
        core_rw_in    = 1'b0;
        for (int i = 0; i < 16; i++) begin
            core_addr_in = 32'h1000 + 32'(i);
            #1;
            n_total++; if (mem_valid_out !== 1'b1) $display("FAIL full_accept%0d: got %b want 1", i, mem_valid_out); else n_pass++;
            step();
        end
        #1;
        n_total++; if (core_stall_out !== 1'b1) $display("FAIL full_stall: got %b want 1", core_stall_out); else n_pass++;
        n_total++; if (mem_valid_out !== 1'b0) $display("FAIL full_mem_valid: got %b want 0", mem_valid_out); else n_pass++;
        step();
        n_total++; if (dut.r_count !== 5'd16) $display("FAIL full_count: got %0d want 16", dut.r_count); else n_pass++;
        core_valid_in = 1'b0;
        mem_ready_in  = 1'b1;
        mem_id_in     = 4'd0;
        mem_data_in   = 32'h5A5A5A5A;
        step();                                   // slot 0 done
        mem_ready_in  = 1'b0;
        n_total++; if (core_stall_out !== 1'b1) $display("FAIL full_stall_hold: got %b want 1", core_stall_out); else n_pass++;
        step();                                   // slot 0 retires
        n_total++; if (core_stall_out !== 1'b0) $display("FAIL full_stall_clear: got %b want 0", core_stall_out); else n_pass++;
        n_total++; if (core_valid_out !== 1'b1) $display("FAIL full_ret_valid: got %b want 1", core_valid_out); else n_pass++;
        n_total++; if (core_data_out !== 32'h5A5A5A5A) $display("FAIL full_ret_data: got %h want 5a5a5a5a", core_data_out); else n_pass++;
        n_total++; if (dut.r_count !== 5'd15) $display("FAIL full_count_after: got %0d want 15", dut.r_count); else n_pass++;
    endtask

    task automatic test_mem_stall();
        do_reset();
        mem_stall_in  = 1'b1;
        core_valid_in = 1'b1;
        core_addr_in  = 32'h200;
        #1;
        n_total++; if (core_stall_out !== 1'b1) $display("FAIL mstall_stall: got %b want 1", core_stall_out); else n_pass++;
        n_total++; if (mem_valid_out !== 1'b0) $display("FAIL mstall_mem_valid: got %b want 0", mem_valid_out); else n_pass++;
        step();
        n_total++; if (dut.r_count !== 5'd0) $display("FAIL mstall_count: got %0d want 0", dut.r_count); else n_pass++;
        mem_stall_in = 1'b0;
        #1;
        n_total++; if (mem_id_out !== 4'd0) $display("FAIL mstall_tail: got %0d want 0", mem_id_out); else n_pass++;
        core_valid_in = 1'b0;
    endtask

    task automatic test_store_err();
        do_reset();
        core_valid_in = 1'b1;
        core_rw_in    = 1'b1;
        core_addr_in  = 32'h80;
        core_data_in  = 32'h00001234;
        #1;
        n_total++; if (mem_rw_out !== 1'b1) $display("FAIL store_mem_rw: got %b want 1", mem_rw_out); else n_pass++;
        n_total++; if (mem_data_out !== 32'h00001234) $display("FAIL store_mem_data: got %h want 00001234", mem_data_out); else n_pass++;
        step();                                   // store accepted as done
        core_rw_in    = 1'b0;
        core_addr_in  = 32'h84;
        step();                                   // load accepted, store retires
        core_valid_in = 1'b0;
        n_total++; if (core_valid_out !== 1'b0) $display("FAIL store_ret_valid: got %b want 0", core_valid_out); else n_pass++;
        n_total++; if (dut.r_count !== 5'd1) $display("FAIL store_count: got %0d want 1", dut.r_count); else n_pass++;
        mem_ready_in  = 1'b1;
        mem_id_in     = 4'd5;
        mem_data_in   = 32'hBAD0BAD0;
        step();
        mem_ready_in  = 1'b0;
        n_total++; if (err_out !== 1'b1) $display("FAIL err_set: got %b want 1", err_out); else n_pass++;
        mem_ready_in  = 1'b1;
        mem_id_in     = 4'd1;
        mem_data_in   = 32'h00000077;
        step();
        mem_ready_in  = 1'b0;
        step();
        n_total++; if (core_valid_out !== 1'b1) $display("FAIL store_load_valid: got %b want 1", core_valid_out); else n_pass++;
        n_total++; if (core_data_out !== 32'h00000077) $display("FAIL store_load_data: got %h want 00000077", core_data_out); else n_pass++;
        n_total++; if (err_out !== 1'b1) $display("FAIL err_sticky: got %b want 1", err_out); else n_pass++;
        do_reset();
        n_total++; if (err_out !== 1'b0) $display("FAIL err_cleared: got %b want 0", err_out); else n_pass++;
    endtask

    task automatic test_reset_pending();
        do_reset();
        issue_load(32'h300);
        issue_load(32'h304);
        issue_load(32'h308);
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_total++; if (dut.r_count !== 5'd0) $display("FAIL rpend_count: got %0d want 0", dut.r_count); else n_pass++;
        n_total++; if (core_valid_out !== 1'b0) $display("FAIL rpend_valid: got %b want 0", core_valid_out); else n_pass++;
        n_total++; if (err_out !== 1'b0) $display("FAIL rpend_err0: got %b want 0", err_out); else n_pass++;
        mem_ready_in = 1'b1;
        mem_id_in    = 4'd1;
        mem_data_in  = 32'hCAFEF00D;
        step();
        mem_ready_in = 1'b0;
        n_total++; if (err_out !== 1'b1) $display("FAIL rpend_late_err: got %b want 1", err_out); else n_pass++;
        step();
        n_total++; if (core_valid_out !== 1'b0) $display("FAIL rpend_no_return: got %b want 0", core_valid_out); else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b1;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_single_load();
        test_reorder();
        test_full();
        test_mem_stall();
        test_store_err();
        test_reset_pending();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
